// File: rtl/mfp_ahb_lite_pkg.sv
// Shared AHB-Lite encodings for the mfp bus masters and slaves.
// Transfer type, burst, size and response constants.
package mfp_ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/mfp_ahb_lite_req_master.sv
// Valid/ready request to AHB-Lite master with pipelined address/data phases.
// Optional macro MFP_AHB_MASTER_ERR_CANCEL_EN cancels the pending transfer on ERROR.
module mfp_ahb_lite_req_master
    import mfp_ahb_lite_pkg::*;
#(
    parameter int STALL_CNT_WIDTH = 16,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [2:0]                 req_size,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_error,
    output logic [31:0]                HADDR,
    output logic [1:0]                 HTRANS,
    output logic                       HWRITE,
    output logic [2:0]                 HSIZE,
    output logic [2:0]                 HBURST,
    output logic [31:0]                HWDATA,
    input  logic [31:0]                HRDATA,
    input  logic                       HREADY,
    input  logic                       HRESP,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
    input  logic                       stat_clear
);

    // Address phase register
    logic                  ap_valid_q, ap_valid_d;
    logic [ADDR_WIDTH-1:0] ap_addr_q, ap_addr_d;
    logic                  ap_write_q, ap_write_d;
    logic [2:0]            ap_size_q, ap_size_d;
    logic [31:0]           ap_wdata_q, ap_wdata_d;

    // Data phase register
    logic                  dp_valid_q, dp_valid_d;
    logic                  dp_write_q, dp_write_d;
    logic [31:0]           hwdata_q, hwdata_d;

    // Response and statistics
    logic                       rsp_valid_q, rsp_valid_d;
    logic [31:0]                rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_error_q, rsp_error_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic        accept;
    logic        stalled;
    logic [31:0] haddr_ext;

`ifdef MFP_AHB_MASTER_ERR_CANCEL_EN
    logic err_first_q, err_first_d;
    logic cancel_pend_q, cancel_pend_d;
    logic cancel_now_q, cancel_now_d;
    logic err_hit;

    assign err_hit   = dp_valid_q & ~HREADY & (HRESP == HRESP_ERROR);
    assign req_ready = HREADY & ~err_first_q;
`else
    assign req_ready = HREADY;
`endif

    assign accept  = req_valid & req_ready;
    assign stalled = dp_valid_q & ~HREADY;

    assign HTRANS    = ap_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = haddr_ext;
    assign HWRITE    = ap_write_q;
    assign HSIZE     = ap_size_q;
    assign HBURST    = HBURST_SINGLE;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign stall_cnt = stall_cnt_q;

    // Zero-extend a narrow request address onto the 32-bit bus
    always_comb begin
        haddr_ext = '0;
        haddr_ext[ADDR_WIDTH-1:0] = ap_addr_q;
    end

    // Advance AP->DP and load a new request whenever the bus is ready
    always_comb begin
        ap_valid_d = ap_valid_q;
        ap_addr_d  = ap_addr_q;
        ap_write_d = ap_write_q;
        ap_size_d  = ap_size_q;
        ap_wdata_d = ap_wdata_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        hwdata_d   = hwdata_q;
        if (HREADY) begin
            dp_valid_d = ap_valid_q;
            dp_write_d = ap_write_q;
            hwdata_d   = ap_wdata_q;
            ap_valid_d = accept;
            if (accept) begin
                ap_addr_d  = req_addr;
                ap_write_d = req_write;
                ap_size_d  = req_size;
                ap_wdata_d = req_wdata;
            end
        end
`ifdef MFP_AHB_MASTER_ERR_CANCEL_EN
        if (err_hit) begin
            ap_valid_d = 1'b0;
        end
`endif
    end

    // One response pulse per completed (or cancelled) transfer
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;
        if (dp_valid_q && HREADY) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = dp_write_q ? 32'h0 : HRDATA;
            rsp_error_d = (HRESP == HRESP_ERROR);
        end
`ifdef MFP_AHB_MASTER_ERR_CANCEL_EN
        if (cancel_now_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
        end
`endif
    end

    // Saturating wait-state counter, clear wins over increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clear) begin
            stall_cnt_d = '0;
        end else if (stalled && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

`ifdef MFP_AHB_MASTER_ERR_CANCEL_EN
    // Track the two-cycle ERROR and schedule the cancelled request's response
    always_comb begin
        err_first_d   = err_first_q;
        cancel_pend_d = cancel_pend_q;
        cancel_now_d  = 1'b0;
        if (err_hit) begin
            err_first_d   = 1'b1;
            cancel_pend_d = cancel_pend_q | ap_valid_q;
        end else if (err_first_q && HREADY) begin
            err_first_d   = 1'b0;
            cancel_pend_d = 1'b0;
            cancel_now_d  = cancel_pend_q;
        end
    end

    // Error tracking state
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_first_q   <= 1'b0;
            cancel_pend_q <= 1'b0;
            cancel_now_q  <= 1'b0;
        end else begin
            err_first_q   <= err_first_d;
            cancel_pend_q <= cancel_pend_d;
            cancel_now_q  <= cancel_now_d;
        end
    end
`endif

    // Pipeline, response and counter state
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ap_valid_q  <= 1'b0;
            ap_addr_q   <= '0;
            ap_write_q  <= 1'b0;
            ap_size_q   <= '0;
            ap_wdata_q  <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ap_valid_q  <= ap_valid_d;
            ap_addr_q   <= ap_addr_d;
            ap_write_q  <= ap_write_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_lite_req_master.sv
// Scoreboard bench for mfp_ahb_lite_req_master with a behavioural AHB slave.
// Honours MFP_AHB_MASTER_ERR_CANCEL_EN when compiled with it.
module tb_mfp_ahb_lite_req_master;
    import mfp_ahb_lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [15:0] stall_cnt;
    logic        stat_clear;

    mfp_ahb_lite_req_master dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP),
        .stall_cnt(stall_cnt), .stat_clear(stat_clear)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;
        bit          err;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [31:0] model_mem[16];
    logic [31:0] slave_mem[16];
    int          checks = 0;
    int          fails = 0;
    int          hr_cnt = 0;
    bit          last_err = 0;
    int          last_idx = 0;
    int          run_ns = 0, max_ns = 0, run_rv = 0, max_rv = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural slave: plan-driven wait states and errors, word memory
    initial begin
        plan_t       s_pl;
        bit          s_act;
        int          s_cnt, total;
        logic        sn_rst, sn_rdy, sn_wr;
        logic [1:0]  sn_trans;
        logic [31:0] sn_addr, sn_wd;
        logic [2:0]  sn_sz, sn_burst;
        s_act = 0; s_cnt = 0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        forever begin
            @(negedge HCLK);
            sn_rst = HRESET; sn_rdy = HREADY; sn_trans = HTRANS;
            sn_addr = HADDR; sn_wr = HWRITE; sn_sz = HSIZE;
            sn_wd = HWDATA; sn_burst = HBURST;
            @(posedge HCLK);
            #1;
            if (sn_rst || HRESET) begin
                s_act = 0;
            end else begin
                if (sn_rdy) hr_cnt++;
                if (s_act && sn_rdy) begin
                    if (s_pl.wr && !s_pl.err) begin
                        chk("hwdata", sn_wd, s_pl.wdata);
                        slave_mem[s_pl.addr[5:2]] = sn_wd;
                    end
                    s_act = 0;
                end
                if (sn_rdy && sn_trans == HTRANS_NONSEQ) begin
                    if (plan_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL addr_phase: got unexpected NONSEQ at %h expected none", sn_addr);
                    end else begin
                        s_pl = plan_q.pop_front();
                        chk("haddr", sn_addr, s_pl.addr);
                        chk("hwrite", {31'h0, sn_wr}, {31'h0, s_pl.wr});
                        chk("hsize", {29'h0, sn_sz}, {29'h0, s_pl.size});
                        chk("hburst", {29'h0, sn_burst}, {29'h0, HBURST_SINGLE});
                        s_act = 1;
                        s_cnt = 0;
                    end
                end else if (s_act) begin
                    s_cnt++;
                end
            end
            if (s_act) begin
                total = s_pl.waits + (s_pl.err ? 2 : 1);
                HREADY = (s_cnt == total - 1);
                HRESP = s_pl.err && (s_cnt >= s_pl.waits);
                HRDATA = s_pl.wr ? $urandom : slave_mem[s_pl.addr[5:2]];
            end else begin
                HREADY = 1'b1;
                HRESP = 1'b0;
                HRDATA = $urandom;
            end
        end
    end

    // Response monitor and run-length tracking
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            run_ns = (HTRANS == HTRANS_NONSEQ) ? run_ns + 1 : 0;
            if (run_ns > max_ns) max_ns = run_ns;
            run_rv = rsp_valid ? run_rv + 1 : 0;
            if (run_rv > max_rv) max_rv = run_rv;
            if (rsp_valid === 1'b1 && !HRESET) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_error", {31'h0, rsp_error}, {31'h0, e.err});
                end
            end
        end
    end

    task automatic send(input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] d,
                        input int ws, input bit er);
        int    n;
        int    idx;
        bit    canc;
        bit    ok;
        plan_t p;
        exp_t  e;
        req_valid = 1'b1; req_write = wr; req_addr = a;
        req_size = sz; req_wdata = d;
        n = 0; ok = 0;
        while (!ok && n < 200) begin
            @(negedge HCLK);
            if (req_ready === 1'b1) ok = 1;
            else n++;
        end
        if (!ok) begin
            checks++; fails++;
            $display("FAIL req_timeout: got no req_ready expected accept within 200 cycles");
            req_valid = 1'b0;
        end else begin
            idx = hr_cnt;
`ifdef MFP_AHB_MASTER_ERR_CANCEL_EN
            canc = last_err && (idx == last_idx + 1);
`else
            canc = 0;
`endif
            if (canc) begin
                e.rdata = 32'h0; e.err = 1'b1;
                last_err = 0;
            end else begin
                p.addr = a; p.wr = wr; p.size = sz; p.wdata = d;
                p.waits = ws; p.err = er;
                plan_q.push_back(p);
                e.err = er;
                e.rdata = wr ? 32'h0 : model_mem[a[5:2]];
                if (wr && !er) model_mem[a[5:2]] = d;
                last_err = er;
                last_idx = idx;
            end
            exp_q.push_back(e);
            @(posedge HCLK);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge HCLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
            plan_q.delete();
        end
        repeat (2) @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_clear();
        stat_clear = 1'b1;
        @(posedge HCLK);
        #1;
        stat_clear = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = '0; req_wdata = '0; stat_clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'h0;
            slave_mem[i] = 32'h0;
        end
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_htrans", {30'h0, HTRANS}, {30'h0, HTRANS_IDLE});
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
        chk("rst_hsize", {29'h0, HSIZE}, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
        chk("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;

        // Zero-wait write then read of the same word
        max_ns = 0; max_rv = 0;
        send(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 0, 0);
        send(1'b0, 32'h10, HSIZE_WORD, 32'h0, 0, 0);
        wait_drain(50);
        chk("t1_nonseq_run", max_ns, 2);
        chk("t1_rsp_run", max_rv, 2);

        // Three wait states on a read with the next request held in AP
        pulse_clear();
        send(1'b0, 32'h20, HSIZE_WORD, 32'h0, 3, 0);
        fork
            send(1'b0, 32'h126, HSIZE_HALF, 32'h0, 0, 0);
            begin
                @(negedge HCLK);
                for (int k = 0; k < 3; k++) begin
                    @(negedge HCLK);
                    chk("t2_hold_haddr", HADDR, 32'h126);
                    chk("t2_hold_htrans", {30'h0, HTRANS}, {30'h0, HTRANS_NONSEQ});
                end
                @(negedge HCLK);
                chk("t2_stall_cnt", {16'h0, stall_cnt}, 32'd3);
            end
        join
        wait_drain(50);

        // Eight back-to-back writes, then read them back
        max_ns = 0; max_rv = 0;
        for (int i = 0; i < 8; i++)
            send(1'b1, 32'h40 + 32'(4 * i), HSIZE_WORD, $urandom, 0, 0);
        wait_drain(50);
        chk("t3_nonseq_run", max_ns, 8);
        chk("t3_rsp_run", max_rv, 8);
        for (int i = 0; i < 8; i++)
            send(1'b0, 32'h40 + 32'(4 * i), HSIZE_WORD, 32'h0, 0, 0);
        wait_drain(50);

        // ERROR on A while B waits in the address phase
        send(1'b0, 32'h30, HSIZE_WORD, 32'h0, 0, 1);
        fork
            send(1'b0, 32'h34, HSIZE_WORD, 32'h0, 0, 0);
            begin
                repeat (3) @(negedge HCLK);
`ifdef MFP_AHB_MASTER_ERR_CANCEL_EN
                chk("t4_htrans_err2", {30'h0, HTRANS}, {30'h0, HTRANS_IDLE});
`else
                chk("t4_htrans_err2", {30'h0, HTRANS}, {30'h0, HTRANS_NONSEQ});
`endif
            end
        join
        wait_drain(50);

        // Asynchronous reset in the middle of a stalled data phase
        send(1'b0, 32'h50, HSIZE_WORD, 32'h0, 3, 0);
        send(1'b0, 32'h54, HSIZE_WORD, 32'h0, 0, 0);
        #2;
        chk("t5_pre_htrans", {30'h0, HTRANS}, {30'h0, HTRANS_NONSEQ});
        HRESET = 1'b1;
        #1;
        chk("t5_rst_htrans", {30'h0, HTRANS}, {30'h0, HTRANS_IDLE});
        chk("t5_rst_rsp", {31'h0, rsp_valid}, 32'h0);
        exp_q.delete();
        plan_q.delete();
        last_err = 0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        send(1'b0, 32'h10, HSIZE_WORD, 32'h0, 0, 0);
        wait_drain(50);

        // Stall counter saturation, then clear during a stall
        pulse_clear();
        send(1'b0, 32'h10, HSIZE_WORD, 32'h0, 65541, 0);
        wait_drain(70000);
        chk("t6_stall_sat", {16'h0, stall_cnt}, 32'h0000FFFF);
        send(1'b0, 32'h14, HSIZE_WORD, 32'h0, 5, 0);
        @(posedge HCLK);
        #1;
        @(posedge HCLK);
        #1;
        stat_clear = 1'b1;
        @(posedge HCLK);
        #1;
        stat_clear = 1'b0;
        @(negedge HCLK);
        chk("t6_stall_clear", {16'h0, stall_cnt}, 32'h0);
        wait_drain(50);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            int g;
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            repeat (g) begin
                @(posedge HCLK);
                #1;
            end
            send(1'($urandom_range(0, 1)), $urandom,
                 3'($urandom_range(0, 2)), $urandom,
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0));
        end
        wait_drain(500);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
